// File: rtl/pulse_parallel_receiver_pkg.sv
// pulse_parallel_receiver_pkg: shared constants and state encoding for the pulse-train receiver.
package pulse_parallel_receiver_pkg;
  localparam int WORD_LENGTH_DEF = 20;
  localparam bit LSB_FIRST = 1'b1;
  typedef enum logic {BLACKOUT = 1'b0, SHIFT = 1'b1} state_e;
endpackage

// File: rtl/pulse_parallel_receiver_bo_edge_detect.sv
// bo_edge_detect: registers the blackout waveform and flags its rising and falling edges.
module bo_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic bo_wf,
  output logic bo_rise,
  output logic bo_fall
);
  logic bo_prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bo_prev_q <= 1'b0;
    else bo_prev_q <= bo_wf;
  assign bo_rise = ~bo_prev_q & bo_wf;
  assign bo_fall = bo_prev_q & ~bo_wf;
endmodule

// File: rtl/pulse_parallel_receiver.sv
// pulse_parallel_receiver: captures a serial digit stream between blackouts into a parallel word.
module pulse_parallel_receiver
  import pulse_parallel_receiver_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int CNT_W = $clog2(WORD_LENGTH + 1)
) (
  input  logic                   w_CLK,
  input  logic                   w_RST_N,
  input  logic                   w_DPG,
  input  logic                   w_BO_WF,
  input  logic                   w_SERIAL_IN,
  output logic [WORD_LENGTH-1:0] b_PX,
  output logic                   w_VALID,
  output logic                   w_ERR,
  output logic                   w_BUSY,
  output logic [CNT_W-1:0]       b_DIGIT_CNT
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_LENGTH);
  state_e state_q, state_d;
  logic [WORD_LENGTH-1:0] sr_q, sr_d, px_q, px_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovr_q, ovr_d, valid_q, valid_d, err_q, err_d, ok;
  logic bo_rise, bo_fall;
  bo_edge_detect u_edge (
    .clk    (w_CLK),
    .rst_n  (w_RST_N),
    .bo_wf  (w_BO_WF),
    .bo_rise(bo_rise),
    .bo_fall(bo_fall)
  );
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    ovr_d = ovr_q;
    px_d = px_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    ok = (cnt_q == FULL) && !ovr_q;
    if (state_q == BLACKOUT) begin
      if (bo_fall) begin
        state_d = SHIFT;
        sr_d = '0;
        cnt_d = '0;
        ovr_d = 1'b0;
      end
    end else if (bo_rise) begin
      // blackout wins over a coincident strobe: word is judged as it stands
      state_d = BLACKOUT;
      valid_d = ok;
      err_d = !ok;
      px_d = ok ? sr_q : px_q;
    end else if (w_DPG && !w_BO_WF) begin
      if (cnt_q < FULL) begin
        sr_d = LSB_FIRST ? {w_SERIAL_IN, sr_q[WORD_LENGTH-1:1]} : {sr_q[WORD_LENGTH-2:0], w_SERIAL_IN};
        cnt_d = cnt_q + CNT_W'(1);
      end else ovr_d = 1'b1;
    end
  end
  always_ff @(posedge w_CLK or negedge w_RST_N)
    if (!w_RST_N) begin
      state_q <= BLACKOUT;
      sr_q <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      px_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      px_q <= px_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  assign b_PX = px_q;
  assign w_VALID = valid_q;
  assign w_ERR = err_q;
  assign w_BUSY = (state_q == SHIFT);
  assign b_DIGIT_CNT = cnt_q;
endmodule

// File: tb/tb_pulse_parallel_receiver.sv
// tb_pulse_parallel_receiver: directed words with a scoreboard of expected valid/error strobes.
module tb_pulse_parallel_receiver;
  logic w_CLK = 1'b0;
  logic w_RST_N = 1'b0;
  logic w_DPG = 1'b0;
  logic w_BO_WF = 1'b1;
  logic w_SERIAL_IN = 1'b0;
  logic [19:0] b_PX;
  logic w_VALID, w_ERR, w_BUSY;
  logic [4:0] b_DIGIT_CNT;
  typedef struct {
    bit          err;
    logic [19:0] px;
    int          cnt;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int passed = 0;
  bit prev_strobe = 1'b0;
  pulse_parallel_receiver dut (
    .w_CLK      (w_CLK),
    .w_RST_N    (w_RST_N),
    .w_DPG      (w_DPG),
    .w_BO_WF    (w_BO_WF),
    .w_SERIAL_IN(w_SERIAL_IN),
    .b_PX       (b_PX),
    .w_VALID    (w_VALID),
    .w_ERR      (w_ERR),
    .w_BUSY     (w_BUSY),
    .b_DIGIT_CNT(b_DIGIT_CNT)
  );
  always #5 w_CLK = ~w_CLK;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic cyc(input logic bo, input logic dpg, input logic sin);
    w_BO_WF = bo;
    w_DPG = dpg;
    w_SERIAL_IN = sin;
    @(posedge w_CLK);
    #1;
  endtask
  task automatic blackout(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask
  // first cycle is the blackout-to-beat edge, then idle/strobe pairs
  task automatic word(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, w[i]);
    end
  endtask
  task automatic expect_strobe(input bit err, input logic [19:0] px, input int cnt);
    exp_t e;
    e.err = err;
    e.px = px;
    e.cnt = cnt;
    sb.push_back(e);
  endtask
  always @(negedge w_CLK) begin
    if (w_VALID || w_ERR) begin
      if (sb.size() == 0) chk("unexpected_strobe", {62'd0, w_VALID, w_ERR}, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_kind", {62'd0, w_VALID, w_ERR}, e.err ? 64'd1 : 64'd2);
        chk("strobe_px", 64'(b_PX), 64'(e.px));
        chk("strobe_cnt", 64'(b_DIGIT_CNT), 64'(e.cnt));
        chk("strobe_spacing", 64'(prev_strobe), 64'd0);
      end
    end
    prev_strobe = w_VALID || w_ERR;
  end
  initial begin
    #1;
    chk("reset_px", 64'(b_PX), 64'd0);
    chk("reset_flags", {61'd0, w_VALID, w_ERR, w_BUSY}, 64'd0);
    chk("reset_cnt", 64'(b_DIGIT_CNT), 64'd0);
    @(posedge w_CLK);
    #1;
    w_RST_N = 1'b1;
    blackout(4);
    expect_strobe(1'b0, 20'hA5C3F, 20);
    word(64'hA5C3F, 20);
    chk("nominal_busy", 64'(w_BUSY), 64'd1);
    blackout(4);
    chk("nominal_idle", 64'(w_BUSY), 64'd0);
    expect_strobe(1'b1, 20'hA5C3F, 19);
    word(64'h12345, 19);
    blackout(4);
    expect_strobe(1'b1, 20'hA5C3F, 20);
    word(64'h000001, 22);
    chk("overrun_sat", 64'(b_DIGIT_CNT), 64'd20);
    blackout(4);
    expect_strobe(1'b1, 20'hA5C3F, 19);
    word(64'hFFFFF, 19);
    cyc(1'b1, 1'b1, 1'b1);
    blackout(3);
    word(64'h3FF, 10);
    w_RST_N = 1'b0;
    #1;
    chk("midreset_px", 64'(b_PX), 64'd0);
    chk("midreset_flags", {61'd0, w_VALID, w_ERR, w_BUSY}, 64'd0);
    chk("midreset_cnt", 64'(b_DIGIT_CNT), 64'd0);
    @(posedge w_CLK);
    #1;
    w_BO_WF = 1'b0;
    w_RST_N = 1'b1;
    word(64'hFF, 5);
    chk("postreset_busy", 64'(w_BUSY), 64'd0);
    chk("postreset_cnt", 64'(b_DIGIT_CNT), 64'd0);
    blackout(4);
    expect_strobe(1'b0, 20'hFFFFF, 20);
    word(64'hFFFFF, 20);
    blackout(4);
    expect_strobe(1'b0, 20'h00000, 20);
    word(64'h00000, 20);
    blackout(4);
    expect_strobe(1'b0, 20'h80000, 20);
    word(64'h80000, 20);
    blackout(4);
    expect_strobe(1'b0, 20'h12345, 20);
    word(64'h12345, 20);
    blackout(4);
    chk("final_px", 64'(b_PX), 64'h12345);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
